// File: rtl/nibble_add_seq.sv
// Nibble-serial adder sequencer driving one shared external 4-bit bitadder.
// Optional subtract mode is enabled with the NIBBLE_ADD_SUB_EN macro.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_c0,
    input  logic [3:0]           add_sol,
    input  logic                 add_c4
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic          state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry_r;
    logic [W-1:0]  b_in;
    logic          c_in;
    logic          last;

    assign last = (idx == IW'(NIBBLES - 1));

    // Subtraction is A + ~B + 1, so only the latched B and carry differ.
    always_comb begin
        b_in = op_b;
        c_in = cin;
`ifdef NIBBLE_ADD_SUB_EN
        if (sub) begin
            b_in = ~op_b;
            c_in = 1'b1;
        end
`endif
    end

    always_comb begin
        add_a  = 4'h0;
        add_b  = 4'h0;
        add_c0 = 1'b0;
        if (state == RUN) begin
            add_a  = a_r[4*idx +: 4];
            add_b  = b_r[4*idx +: 4];
            add_c0 = carry_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cout    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= op_a;
                        b_r     <= b_in;
                        carry_r <= c_in;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result[4*idx +: 4] <= add_sol;
                    carry_r            <= add_c4;
                    if (last) begin
                        cout  <= add_c4;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
